// File: rtl/vga_wr_queue_if.sv
// Pixel-write bus between the CPU VGA port and the write queue, plus the
// queue's status and video memory write outputs.
interface vga_wr_queue_if #(
  parameter int DEPTH = 8,
  parameter int XW    = 8,
  parameter int YW    = 8,
  parameter int CW    = 3
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            wr_en;
  logic [XW-1:0]   wr_x;
  logic [YW-1:0]   wr_y;
  logic [CW-1:0]   wr_c;
  logic            blank;
  logic            full;
  logic            empty;
  logic [CNTW-1:0] count;
  logic            overflow;
  logic            mem_we;
  logic [XW-1:0]   mem_x;
  logic [YW-1:0]   mem_y;
  logic [CW-1:0]   mem_c;

  modport master (
    output wr_en, wr_x, wr_y, wr_c, blank,
    input  full, empty, count, overflow, mem_we, mem_x, mem_y, mem_c
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_c, blank,
    output full, empty, count, overflow, mem_we, mem_x, mem_y, mem_c
  );
endinterface

// File: rtl/vga_wr_queue.sv
// CPU pixel-write FIFO that drains into video memory only during blanking.
// Define VGA_WR_COALESCE_EN to merge repeated writes to the newest queued pixel.
module vga_wr_queue #(
  parameter int DEPTH = 8,
  parameter int XW    = 8,
  parameter int YW    = 8,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  vga_wr_queue_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for blank with entries queued; never pops
  // DRAIN | pops one entry per cycle while blank=1
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = XW + YW + CW;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [EW-1:0]   store [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CNTW-1:0] count_q, count_nxt;
  logic [0:0]      state;
  logic            ovf_q, full, empty, pop, push, drop, coal;
  logic            we_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   c_q;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = (state == DRAIN) && bus.blank && !empty;

`ifdef VGA_WR_COALESCE_EN
  logic [AW-1:0] last_ptr;
  assign last_ptr = wr_ptr - 1'b1;
  // The newest entry can only be the head being popped when it is the sole entry.
  assign coal = bus.wr_en && !empty
             && (store[last_ptr][EW-1:CW] == {bus.wr_x, bus.wr_y})
             && !(pop && (rd_ptr == last_ptr));
`else
  assign coal = 1'b0;
`endif

  assign push = bus.wr_en && !full && !coal;
  assign drop = bus.wr_en && full && !coal;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      store[wr_ptr] <= {bus.wr_x, bus.wr_y, bus.wr_c};
`ifdef VGA_WR_COALESCE_EN
    else if (coal)
      store[last_ptr][CW-1:0] <= bus.wr_c;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      state   <= IDLE;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
    end else begin
      count_q <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (drop) ovf_q <= 1'b1;
      we_q <= pop;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        x_q    <= store[rd_ptr][EW-1 -: XW];
        y_q    <= store[rd_ptr][CW +: YW];
        c_q    <= store[rd_ptr][CW-1:0];
      end
      case (state)
        IDLE:    if (bus.blank && !empty) state <= DRAIN;
        DRAIN:   if (!bus.blank || (count_nxt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_x    = x_q;
  assign bus.mem_y    = y_q;
  assign bus.mem_c    = c_q;
endmodule

// File: tb/tb_vga_wr_queue.sv
// Randomized and directed bench for vga_wr_queue against a queue-based model
// of the pixel FIFO and blanking-gated drain.
module tb_vga_wr_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  vga_wr_queue_if #(.DEPTH(DEPTH), .XW(8), .YW(8), .CW(3)) bus ();

  vga_wr_queue #(.DEPTH(DEPTH), .XW(8), .YW(8), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  pix_t       q[$];
  bit         draining;
  bit         ovf;
  bit         exp_we;
  logic [7:0] ex, ey;
  logic [2:0] ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    draining = 0;
    ovf = 0;
    exp_we = 0;
    ex = '0;
    ey = '0;
    ec = '0;
  endtask

  task automatic model_edge(input logic en, input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] c, input logic b);
    int   n0;
    bit   full0, pop, co;
    pix_t p;
    n0    = q.size();
    full0 = (n0 == DEPTH);
    pop   = draining && b && (n0 > 0);
    co    = 0;
`ifdef VGA_WR_COALESCE_EN
    if (en && n0 > 0 && q[n0-1].x == x && q[n0-1].y == y && !(pop && n0 == 1)) co = 1;
`endif
    if (pop) begin
      p = q.pop_front();
      exp_we = 1;
      ex = p.x;
      ey = p.y;
      ec = p.c;
    end else begin
      exp_we = 0;
    end
    if (co) q[q.size()-1].c = c;
    else if (en) begin
      if (full0) ovf = 1;
      else q.push_back('{x: x, y: y, c: c});
    end
    if (draining) draining = b && (q.size() > 0);
    else          draining = b && (n0 > 0);
  endtask

  task automatic compare_all();
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("overflow", 32'(bus.overflow), 32'(ovf));
    chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
    chk("mem_x", 32'(bus.mem_x), 32'(ex));
    chk("mem_y", 32'(bus.mem_y), 32'(ey));
    chk("mem_c", 32'(bus.mem_c), 32'(ec));
  endtask

  task automatic step(input logic en, input logic [7:0] x, input logic [7:0] y,
                      input logic [2:0] c, input logic b);
    bus.wr_en = en;
    bus.wr_x  = x;
    bus.wr_y  = y;
    bus.wr_c  = c;
    bus.blank = b;
    @(posedge clk);
    model_edge(en, x, y, c, b);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.blank = 1'b0;
    reset = 1'b1;
    #2;
    model_clear();
    compare_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int pct;
    bus.wr_en = 1'b0;
    bus.wr_x  = '0;
    bus.wr_y  = '0;
    bus.wr_c  = '0;
    bus.blank = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // single pixel latency with blank held high
    step(1'b1, 8'd5, 8'd7, 3'd3, 1'b1);
    chk("lat_push", 32'(bus.mem_we), 32'd0);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    chk("lat_enter", 32'(bus.mem_we), 32'd0);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    chk("lat_we", 32'(bus.mem_we), 32'd1);
    chk("lat_xyc", {13'd0, bus.mem_x, bus.mem_y, bus.mem_c}, {13'd0, 8'd5, 8'd7, 3'd3});
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    chk("lat_one", 32'(bus.mem_we), 32'd0);

    // fill, overflow, then full drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(i + 10), 8'(i + 20), 3'(i), 1'b0);
      if (i == 7) chk("t3_full", 32'(bus.full), 32'd1);
    end
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
      if (bus.mem_we) pulses++;
    end
    chk("t3_pulses", 32'(pulses), 32'd8);
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // blank dropped for one cycle mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 1), 8'(i + 2), 3'(i + 4), 1'b0);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    chk("t4_gap", 32'(bus.mem_we), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    chk("t4_empty", 32'(bus.empty), 32'd1);

    // repeated address: coalesced or kept separate depending on build
    do_reset();
    step(1'b1, 8'd1, 8'd1, 3'd2, 1'b0);
    step(1'b1, 8'd1, 8'd1, 3'd6, 1'b0);
`ifdef VGA_WR_COALESCE_EN
    chk("t6_count", 32'(bus.count), 32'd1);
`else
    chk("t6_count", 32'(bus.count), 32'd2);
`endif
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);

    // randomized traffic with shifting blank density and occasional resets
    pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 30;
          2: pct = 90;
          default: pct = 100;
        endcase
      end
      if (i % 900 == 899) do_reset();
      step(($urandom_range(0, 99) < 60), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
           3'($urandom), ($urandom_range(0, 99) < pct));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
